// File: rtl/sched_pkg.sv
// Shared encodings for the AXIS QoS scheduler: FSM states and arbitration modes.
package sched_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam logic MODE_STRICT = 1'b0;
  localparam logic MODE_DRR    = 1'b1;

endpackage

// File: rtl/keep_popcount.sv
// Counts the set bits of a tkeep vector, i.e. the number of valid bytes in a beat.
module keep_popcount #(
  parameter int KEEP_WIDTH = 8
) (
  input  logic [KEEP_WIDTH-1:0]         keep,
  output logic [$clog2(KEEP_WIDTH+1)-1:0] count
);

  localparam int CW = $clog2(KEEP_WIDTH + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      count = count + CW'(keep[i]);
    end
  end

endmodule

// File: rtl/axis_qos_scheduler.sv
// Packet-atomic AXI-stream scheduler: N input queues onto one output, strict priority or DRR.
// state | meaning
// ARB   | no beat moves; pick a queue (strict scan or one DRR pointer step per cycle)
// XFER  | granted queue wired to the output until its tlast handshake
module axis_qos_scheduler
  import sched_pkg::*;
#(
  parameter int N_QUEUE       = 3,
  parameter int DATA_WIDTH    = 64,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int QUANTUM_WIDTH = 16,
  parameter int DEFICIT_WIDTH = QUANTUM_WIDTH + 2,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_QUEUE*DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [N_QUEUE*KEEP_WIDTH-1:0]     s_axis_tkeep,
  input  logic [N_QUEUE-1:0]                s_axis_tvalid,
  input  logic [N_QUEUE-1:0]                s_axis_tlast,
  output logic [N_QUEUE-1:0]                s_axis_tready,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]             m_axis_tkeep,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [$clog2(N_QUEUE)-1:0]        m_axis_tid,
  input  logic                              cfg_enable,
  input  logic                              cfg_mode,
  input  logic [N_QUEUE*QUANTUM_WIDTH-1:0]  cfg_quantum,
  input  logic                              stat_clear,
  output logic [N_QUEUE*CNT_WIDTH-1:0]      stat_pkt_count
);

  localparam int IDXW = $clog2(N_QUEUE);
  localparam int PCW  = $clog2(KEEP_WIDTH + 1);
  localparam logic signed [DEFICIT_WIDTH:0] DEF_MAX = {2'b00, {(DEFICIT_WIDTH-1){1'b1}}};
  localparam logic signed [DEFICIT_WIDTH:0] DEF_MIN = {2'b11, {(DEFICIT_WIDTH-1){1'b0}}};

  state_e                          state_q, state_d;
  logic [IDXW-1:0]                 grant_q, grant_d;
  logic [IDXW-1:0]                 ptr_q, ptr_d;
  logic                            drr_q, drr_d;
  logic signed [DEFICIT_WIDTH-1:0] deficit_q [N_QUEUE];
  logic signed [DEFICIT_WIDTH-1:0] deficit_d [N_QUEUE];
  logic [CNT_WIDTH-1:0]            cnt_q [N_QUEUE];
  logic [CNT_WIDTH-1:0]            cnt_d [N_QUEUE];

  logic [DATA_WIDTH-1:0]           g_data;
  logic [KEEP_WIDTH-1:0]           g_keep;
  logic                            g_valid;
  logic                            g_last;
  logic [PCW-1:0]                  beat_bytes;
  logic                            hs;
  logic                            any_valid;
  logic [IDXW-1:0]                 low_idx;
  logic signed [DEFICIT_WIDTH:0]   add_raw, sub_raw;
  logic signed [DEFICIT_WIDTH-1:0] add_sat, sub_sat;
  logic                            ptr_def_pos;

  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
    return (i == IDXW'(N_QUEUE - 1)) ? '0 : i + IDXW'(1);
  endfunction

  always_comb begin
    g_data  = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
    g_keep  = s_axis_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH];
    g_valid = s_axis_tvalid[grant_q];
    g_last  = s_axis_tlast[grant_q];
  end

  keep_popcount #(.KEEP_WIDTH(KEEP_WIDTH)) u_keep_popcount (
    .keep  (g_keep),
    .count (beat_bytes)
  );

  assign hs = (state_q == XFER) && g_valid && m_axis_tready;

  always_comb begin
    any_valid = 1'b0;
    low_idx   = '0;
    for (int i = N_QUEUE - 1; i >= 0; i--) begin
      if (s_axis_tvalid[i]) begin
        any_valid = 1'b1;
        low_idx   = IDXW'(i);
      end
    end
  end

  // Deficit arithmetic is done one bit wider so both saturation limits are exact.
  always_comb begin
    add_raw = {deficit_q[ptr_q][DEFICIT_WIDTH-1], deficit_q[ptr_q]}
            + {{(DEFICIT_WIDTH+1-QUANTUM_WIDTH){1'b0}},
               cfg_quantum[ptr_q*QUANTUM_WIDTH +: QUANTUM_WIDTH]};
    sub_raw = {deficit_q[grant_q][DEFICIT_WIDTH-1], deficit_q[grant_q]}
            - {{(DEFICIT_WIDTH+1-PCW){1'b0}}, beat_bytes};
    add_sat = (add_raw > DEF_MAX) ? DEF_MAX[DEFICIT_WIDTH-1:0] : add_raw[DEFICIT_WIDTH-1:0];
    sub_sat = (sub_raw < DEF_MIN) ? DEF_MIN[DEFICIT_WIDTH-1:0] : sub_raw[DEFICIT_WIDTH-1:0];
    ptr_def_pos = !deficit_q[ptr_q][DEFICIT_WIDTH-1] && (|deficit_q[ptr_q]);
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    drr_d     = drr_q;
    deficit_d = deficit_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      ARB: begin
        if (cfg_enable) begin
          if (cfg_mode == MODE_STRICT) begin
            if (any_valid) begin
              grant_d = low_idx;
              drr_d   = MODE_STRICT;
              state_d = XFER;
            end
          end else if (s_axis_tvalid[ptr_q]) begin
            if (ptr_def_pos) begin
              grant_d = ptr_q;
              drr_d   = MODE_DRR;
              state_d = XFER;
            end else begin
              deficit_d[ptr_q] = add_sat;
              ptr_d            = next_idx(ptr_q);
            end
          end else begin
            deficit_d[ptr_q] = '0;
            ptr_d            = next_idx(ptr_q);
          end
        end
      end
      XFER: begin
        if (hs) begin
          if (drr_q) deficit_d[grant_q] = sub_sat;
          if (g_last) begin
            cnt_d[grant_q] = cnt_q[grant_q] + CNT_WIDTH'(1);
            state_d        = ARB;
            if (drr_q) ptr_d = next_idx(grant_q);
          end
        end
      end
      default: state_d = ARB;
    endcase
    if (stat_clear) begin
      for (int i = 0; i < N_QUEUE; i++) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      grant_q <= '0;
      ptr_q   <= '0;
      drr_q   <= MODE_STRICT;
      for (int i = 0; i < N_QUEUE; i++) begin
        deficit_q[i] <= '0;
        cnt_q[i]     <= '0;
      end
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      drr_q     <= drr_d;
      deficit_q <= deficit_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    s_axis_tready = '0;
    m_axis_tdata  = g_data;
    m_axis_tkeep  = g_keep;
    m_axis_tlast  = g_last;
    m_axis_tvalid = 1'b0;
    m_axis_tid    = '0;
    if (state_q == XFER) begin
      s_axis_tready[grant_q] = m_axis_tready;
      m_axis_tvalid          = g_valid;
      m_axis_tid             = grant_q;
    end
  end

  always_comb begin
    stat_pkt_count = '0;
    for (int i = 0; i < N_QUEUE; i++) begin
      stat_pkt_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_axis_qos_scheduler.sv
// Directed bench for axis_qos_scheduler: strict priority, DRR fairness/weighting, back-pressure, enable, stat clear, reset.
module tb_axis_qos_scheduler;

  localparam int N  = 3;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int QW = 16;
  localparam int CW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N*DW-1:0]   s_tdata;
  logic [N*KW-1:0]   s_tkeep;
  logic [N-1:0]      s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tvalid, m_tlast, m_tready;
  logic [1:0]        m_tid;
  logic              cfg_enable, cfg_mode, stat_clear;
  logic [N*QW-1:0]   cfg_quantum;
  logic [N*CW-1:0]   stat;

  logic [15:0] src_beat [N];
  logic [15:0] src_pkt  [N];
  logic [15:0] src_lim  [N];
  logic [15:0] plen     [N];

  typedef struct {
    logic [1:0]  tid;
    logic [63:0] data;
    logic        last;
    int          cyc;
  } beat_t;
  beat_t beat_log [$];
  int    cyc = 0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_qos_scheduler #(
    .N_QUEUE(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .QUANTUM_WIDTH(QW),
    .DEFICIT_WIDTH(QW+2), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready), .m_axis_tid(m_tid),
    .cfg_enable(cfg_enable), .cfg_mode(cfg_mode), .cfg_quantum(cfg_quantum),
    .stat_clear(stat_clear), .stat_pkt_count(stat)
  );

  // Always-backlogged sources limited by src_lim; each beat tagged with queue/packet/beat.
  always_comb begin
    s_tdata  = '0;
    s_tkeep  = '1;
    s_tvalid = '0;
    s_tlast  = '0;
    for (int q = 0; q < N; q++) begin
      s_tdata[q*DW +: DW] = {16'(q), src_pkt[q], src_beat[q], 16'h5A5A};
      s_tvalid[q]         = src_pkt[q] < src_lim[q];
      s_tlast[q]          = src_beat[q] == plen[q] - 16'd1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int q = 0; q < N; q++) begin
        src_beat[q] <= '0;
        src_pkt[q]  <= '0;
      end
    end else begin
      for (int q = 0; q < N; q++) begin
        if (s_tvalid[q] && s_tready[q]) begin
          if (s_tlast[q]) begin
            src_beat[q] <= '0;
            src_pkt[q]  <= src_pkt[q] + 16'd1;
          end else begin
            src_beat[q] <= src_beat[q] + 16'd1;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && m_tvalid && m_tready) beat_log.push_back('{m_tid, m_tdata, m_tlast, cyc});
  end

  function automatic logic [63:0] exp_data(int q, int pkt, int b);
    return {16'(q), 16'(pkt), 16'(b), 16'h5A5A};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_log(int n, int budget, string tag);
    int k = 0;
    while (beat_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(beat_log.size() >= n), 64'd1);
  endtask

  task automatic chk_pkt(string tag, int idx, int q, int pkt, int nb);
    beat_t e;
    for (int b = 0; b < nb; b++) begin
      if (idx + b < beat_log.size()) e = beat_log[idx+b];
      else e = '{2'bxx, 'x, 1'bx, 0};
      chk({tag, "_tid"},  64'(e.tid),  64'(q));
      chk({tag, "_data"}, e.data,      exp_data(q, pkt, b));
      chk({tag, "_last"}, 64'(e.last), 64'(b == nb - 1));
    end
  endtask

  function automatic logic [63:0] cnt_of(int q);
    return 64'(stat[q*CW +: CW]);
  endfunction

  task automatic do_reset();
    rst_n       = 1'b0;
    cfg_enable  = 1'b1;
    cfg_mode    = 1'b0;
    cfg_quantum = {16'd64, 16'd64, 16'd64};
    stat_clear  = 1'b0;
    m_tready    = 1'b1;
    for (int q = 0; q < N; q++) begin
      src_lim[q] = '0;
      plen[q]    = 16'd3;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beat_log.delete();
  endtask

  initial begin
    bit tr;
    bit found;
    int k;

    // Reset state
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tid",    64'(m_tid),    64'd0);
    chk("rst_stat",     64'(stat == '0), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Strict priority: queues 0 and 2 with one 3-beat packet each
    do_reset();
    src_lim[0] = 16'd1;
    src_lim[2] = 16'd1;
    wait_log(6, 60, "sp_timeout");
    chk_pkt("sp_q0", 0, 0, 0, 3);
    chk_pkt("sp_q2", 3, 2, 0, 3);
    if (beat_log.size() >= 6) chk("sp_idle_gap", 64'(beat_log[3].cyc - beat_log[2].cyc), 64'd2);
    @(negedge clk);
    chk("sp_cnt0", cnt_of(0), 64'd1);
    chk("sp_cnt1", cnt_of(1), 64'd0);
    chk("sp_cnt2", cnt_of(2), 64'd1);

    // DRR fairness: equal quanta, 8-beat packets -> 0,1,2,0,1,2
    do_reset();
    cfg_mode = 1'b1;
    for (int q = 0; q < N; q++) begin
      plen[q]    = 16'd8;
      src_lim[q] = 16'd2;
    end
    wait_log(48, 400, "drr_fair_timeout");
    for (int p = 0; p < 6; p++) chk_pkt("drr_fair", p*8, p % 3, p / 3, 8);
    @(negedge clk);
    for (int q = 0; q < N; q++) chk("drr_fair_cnt", cnt_of(q), 64'd2);

    // DRR weighting: queue 0 quantum 128 -> 0,1,2,0,1,2,0,0
    do_reset();
    cfg_mode    = 1'b1;
    cfg_quantum = {16'd64, 16'd64, 16'd128};
    for (int q = 0; q < N; q++) plen[q] = 16'd8;
    src_lim[0] = 16'd4;
    src_lim[1] = 16'd2;
    src_lim[2] = 16'd2;
    wait_log(64, 600, "drr_wt_timeout");
    chk_pkt("drr_wt0", 0,  0, 0, 8);
    chk_pkt("drr_wt1", 8,  1, 0, 8);
    chk_pkt("drr_wt2", 16, 2, 0, 8);
    chk_pkt("drr_wt3", 24, 0, 1, 8);
    chk_pkt("drr_wt4", 32, 1, 1, 8);
    chk_pkt("drr_wt5", 40, 2, 1, 8);
    chk_pkt("drr_wt6", 48, 0, 2, 8);
    chk_pkt("drr_wt7", 56, 0, 3, 8);
    @(negedge clk);
    chk("drr_wt_cnt0", cnt_of(0), 64'd4);
    chk("drr_wt_cnt1", cnt_of(1), 64'd2);
    chk("drr_wt_cnt2", cnt_of(2), 64'd2);

    // Back-pressure: m_tready toggles every cycle, queues 0 and 1 pending
    do_reset();
    for (int q = 0; q < N; q++) plen[q] = 16'd4;
    src_lim[0] = 16'd1;
    src_lim[1] = 16'd1;
    tr = 1'b1;
    k  = 0;
    while (beat_log.size() < 8 && k < 80) begin
      m_tready = tr;
      #1;
      if (m_tvalid) begin
        for (int q = 0; q < N; q++) begin
          if (q == int'(m_tid)) chk("bp_ready_grant", 64'(s_tready[q]), 64'(m_tready));
          else chk("bp_ready_other", 64'(s_tready[q]), 64'd0);
        end
      end
      @(negedge clk);
      tr = ~tr;
      k++;
    end
    m_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_beats", 64'(beat_log.size()), 64'd8);
    chk_pkt("bp_q0", 0, 0, 0, 4);
    chk_pkt("bp_q1", 4, 1, 0, 4);

    // Enable dropped on beat 2 of a 4-beat packet
    do_reset();
    for (int q = 0; q < N; q++) plen[q] = 16'd4;
    src_lim[0] = 16'd2;
    wait_log(2, 40, "en_timeout");
    cfg_enable = 1'b0;
    repeat (20) @(negedge clk);
    chk("en_beats", 64'(beat_log.size()), 64'd4);
    chk_pkt("en_q0", 0, 0, 0, 4);
    chk("en_idle_valid", 64'(m_tvalid), 64'd0);
    chk("en_cnt0", cnt_of(0), 64'd1);

    // stat_clear coincident with the tlast handshake of the next packet
    beat_log.delete();
    cfg_enable = 1'b1;
    found = 1'b0;
    k     = 0;
    while (!found && k < 40) begin
      #1;
      if (m_tvalid && m_tlast && m_tready) begin
        stat_clear = 1'b1;
        found      = 1'b1;
      end
      @(negedge clk);
      stat_clear = 1'b0;
      k++;
    end
    chk("clr_seen_tlast", 64'(found), 64'd1);
    chk("clr_cnt0", cnt_of(0), 64'd0);
    chk_pkt("clr_q0", 0, 0, 1, 4);

    // Reset asserted mid-packet in DRR mode
    do_reset();
    cfg_mode = 1'b1;
    for (int q = 0; q < N; q++) begin
      plen[q]    = 16'd8;
      src_lim[q] = 16'd1;
    end
    wait_log(3, 100, "rmp_timeout");
    chk("rmp_pre_valid", 64'(m_tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rmp_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rmp_s_tready", 64'(s_tready), 64'd0);
    chk("rmp_m_tid",    64'(m_tid),    64'd0);
    chk("rmp_ptr",      64'(dut.ptr_q), 64'd0);
    for (int q = 0; q < N; q++) chk("rmp_deficit", 64'(dut.deficit_q[q]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    beat_log.delete();
    wait_log(8, 100, "rmp_restart_timeout");
    chk_pkt("rmp_restart", 0, 0, 0, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
